// File: rtl/accum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_ctrl_pkg
//  Description : Shared types and constants for the accumulate sequencer.
//                This covers the FSM state encoding, the operand select codes
//                and the layout of one step field.
//  Revision    : 1.0  initial release
// ============================================================================
package accum_ctrl_pkg;

  // One step field is {sub, sel[1:0]}
  localparam int OP_W    = 3;
  localparam int SUB_BIT = 2;
  localparam int SEL_LSB = 0;
  localparam int SEL_W   = 2;

  // Operand select codes as seen on {s2,s1}
  localparam logic [1:0] SEL_B   = 2'b00;
  localparam logic [1:0] SEL_C   = 2'b01;
  localparam logic [1:0] SEL_D   = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/accum_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : accum_ctrl_if
//  Description : Command handshake between the command source (master) and
//                the accumulate sequencer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface accum_ctrl_if #(
  parameter int MAX_OPS = 3,
  parameter int CNT_W   = 2
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CNT_W-1:0]     cmd_len;
  logic [3*MAX_OPS-1:0] cmd_ops;

  modport master (
    output cmd_valid,
    output cmd_len,
    output cmd_ops,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_len,
    input  cmd_ops,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/accum_ctrl_step_dec.sv
`default_nettype none
// ============================================================================
//  Module      : accum_ctrl_step_dec
//  Description : Decodes one {sub, sel} step field into the datapath pins used
//                during a STEP cycle. The reserved select code suppresses the
//                flop load so that the accumulator holds its value.
//  Revision    : 1.0  initial release
// ============================================================================
module accum_ctrl_step_dec
  import accum_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            m,
  output logic            s1,
  output logic            s2,
  output logic            e
);

  // Map the select code onto the operand mux and gate the load on reserved codes
  always_comb begin
    m  = op[SUB_BIT];
    s1 = 1'b0;
    s2 = 1'b0;
    e  = 1'b1;
    case (op[SEL_LSB +: SEL_W])
      SEL_B: begin
      end
      SEL_C: s1 = 1'b1;
      SEL_D: s2 = 1'b1;
      default: begin
        // Reserved: keep the operand mux parked and hold the flop
        m = 1'b0;
        e = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : accum_ctrl
//  Description : Sequencer for the 8-bit accumulate datapath. It accepts one
//                command, loads A, runs up to MAX_OPS add/sub steps and then
//                pulses done.
//                Optional macro ACCUM_CTRL_ABORT_EN adds an 'abort' input that
//                returns LOAD/STEP to IDLE without a done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int MAX_OPS = 3,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef ACCUM_CTRL_ABORT_EN
  input  logic        abort,
`endif
  accum_ctrl_if.slave cmd,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        m,
  output logic        e,
  output logic        busy,
  output logic        done
);

  localparam int             N_SLOTS = 2 ** CNT_W;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_OPS);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         len_q;
  logic [OP_W*MAX_OPS-1:0]  ops_q;
  logic [CNT_W-1:0]         len_clamped;
  logic                     accept;
  logic                     last_step;
  logic                     abort_req;
  logic [OP_W-1:0]          op_arr [N_SLOTS];
  logic [OP_W-1:0]          cur_op;
  logic                     dec_m;
  logic                     dec_s1;
  logic                     dec_s2;
  logic                     dec_e;

  assign cmd.cmd_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign len_clamped   = (cmd.cmd_len > MAX_LEN) ? MAX_LEN : cmd.cmd_len;
  assign last_step     = (cnt == (len_q - CNT_W'(1)));

`ifdef ACCUM_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Split the latched step word into per-step fields; unused counter codes read as zero
  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_ops
      if (gi < MAX_OPS) begin : g_fld
        assign op_arr[gi] = ops_q[gi*OP_W +: OP_W];
      end else begin : g_pad
        assign op_arr[gi] = '0;
      end
    end
  endgenerate

  assign cur_op = op_arr[cnt];

  accum_ctrl_step_dec u_step_dec (
    .op (cur_op),
    .m  (dec_m),
    .s1 (dec_s1),
    .s2 (dec_s2),
    .e  (dec_e)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch and step counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      ops_q <= '0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        len_q <= len_clamped;
        ops_q <= cmd.cmd_ops;
      end
      if (state == ST_LOAD) begin
        cnt <= '0;
      end else if (state == ST_STEP) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (abort_req)            state_nxt = ST_IDLE;
        else if (len_q != '0)     state_nxt = ST_STEP;
        else                      state_nxt = ST_DONE;
      end
      ST_STEP: begin
        if (abort_req)            state_nxt = ST_IDLE;
        else if (last_step)       state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = accept ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state and latched step fields only
  always_comb begin
    s0   = 1'b0;
    s1   = 1'b0;
    s2   = 1'b0;
    m    = 1'b0;
    e    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_LOAD: begin
        busy = 1'b1;
        e    = 1'b1;
      end
      ST_STEP: begin
        busy = 1'b1;
        s0   = 1'b1;
        m    = dec_m;
        s1   = dec_s1;
        s2   = dec_s2;
        e    = dec_e;
      end
      ST_DONE: done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_ctrl
//  Description : Self-checking bench: accum_ctrl driving a behavioural 8-bit
//                accumulate datapath. It applies a directed vector table,
//                hand-written reset, back-to-back and (optionally) abort
//                sequences, and randomized commands checked against a
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_accum_ctrl;

  logic clk;
  logic reset;
  logic s0, s1, s2, m, e, busy, done;
`ifdef ACCUM_CTRL_ABORT_EN
  logic abort;
`endif

  logic [7:0] a_val, b_val, c_val, d_val;
  logic [7:0] acc;
  logic [7:0] opnd;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;

  accum_ctrl_if #(.MAX_OPS(3), .CNT_W(2)) cmd_if ();

  accum_ctrl #(.MAX_OPS(3), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef ACCUM_CTRL_ABORT_EN
    .abort (abort),
`endif
    .cmd   (cmd_if),
    .s0    (s0),
    .s1    (s1),
    .s2    (s2),
    .m     (m),
    .e     (e),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: mux2to1 A/adder -> flop, adder/sub on a 3:1 B/C/D mux
  always_comb begin
    case ({s2, s1})
      2'b00:   opnd = b_val;
      2'b01:   opnd = c_val;
      2'b10:   opnd = d_val;
      default: opnd = 8'h00;
    endcase
    sum = m ? (acc - opnd) : (acc + opnd);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  acc <= 8'h00;
    else if (e)  acc <= s0 ? sum : a_val;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: A followed by each non-reserved step applied with wrap at 256
  function automatic logic [7:0] ref_result(input logic [7:0] a, input int len,
                                            input logic [8:0] ops);
    int r;
    int v;
    r = a;
    for (int i = 0; i < len; i++) begin
      case (ops[3*i +: 2])
        2'd0: v = b_val;
        2'd1: v = c_val;
        2'd2: v = d_val;
        default: v = -1;
      endcase
      if (v >= 0) r = ops[3*i+2] ? (r - v) : (r + v);
    end
    return 8'(r & 255);
  endfunction

  function automatic int ref_loads(input int len, input logic [8:0] ops);
    int n;
    n = 1;
    for (int i = 0; i < len; i++) if (ops[3*i +: 2] != 2'b11) n++;
    return n;
  endfunction

  // Presents a command in the current cycle (caller sits at a negedge in IDLE or DONE)
  // and returns at the negedge of the cycle where done is seen, or after a bound.
  task automatic run_cmd(input logic [1:0] len, input logic [8:0] ops, input logic [7:0] a,
                         input bit noise, output int lat, output int ecnt,
                         output logic [7:0] res, output logic s0_first);
    bit seen_e;
    a_val            = a;
    cmd_if.cmd_len   = len;
    cmd_if.cmd_ops   = ops;
    cmd_if.cmd_valid = 1'b1;
    lat = -1; ecnt = 0; res = 8'h00; s0_first = 1'b1; seen_e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      if (noise && k == 2) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ops   = 9'($urandom);
      end
      if (noise && k == 3) cmd_if.cmd_valid = 1'b0;
      if (e) begin
        ecnt++;
        if (!seen_e) begin
          s0_first = s0;
          seen_e   = 1'b1;
        end
      end
      if (done) begin
        lat = k;
        res = acc;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] len;
    logic [8:0] ops;
    logic [7:0] a;
    logic [7:0] exp_res;
    int         exp_e;
  } vec_t;

  vec_t vecs [5];

  int         lat, ecnt;
  logic [7:0] res;
  logic       s0f;
  logic [1:0] rlen;
  logic [8:0] rops;
  logic [7:0] ra;
  logic [7:0] exp_r;
  int         exp_l;

  initial begin
    vecs[0] = '{len: 2'd3, ops: 9'b010_101_000, a: 8'd10,  exp_res: 8'd9,   exp_e: 4};
    vecs[1] = '{len: 2'd0, ops: 9'b000_000_000, a: 8'd10,  exp_res: 8'd10,  exp_e: 1};
    vecs[2] = '{len: 2'd2, ops: 9'b000_001_000, a: 8'd250, exp_res: 8'd2,   exp_e: 3};
    vecs[3] = '{len: 2'd1, ops: 9'b000_000_100, a: 8'd0,   exp_res: 8'd253, exp_e: 2};
    vecs[4] = '{len: 2'd3, ops: 9'b010_011_000, a: 8'd10,  exp_res: 8'd14,  exp_e: 3};

    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_len   = '0;
    cmd_if.cmd_ops   = '0;
`ifdef ACCUM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    a_val = 8'd10; b_val = 8'd3; c_val = 8'd5; d_val = 8'd1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {s0, s1, s2, m, e, busy, done}, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    chk("rst_acc", acc, 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed vectors
    foreach (vecs[i]) begin
      run_cmd(vecs[i].len, vecs[i].ops, vecs[i].a, 1'b0, lat, ecnt, res, s0f);
      chk($sformatf("vec%0d_lat", i), lat, int'(vecs[i].len) + 2);
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_ecnt", i), ecnt, vecs[i].exp_e);
      chk($sformatf("vec%0d_s0_load", i), s0f, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_hold", i), acc, vecs[i].exp_res);
      chk($sformatf("vec%0d_idle", i), {busy, done, e}, 0);
    end

    // Back-to-back: second command presented during DONE
    run_cmd(2'd1, 9'b000_000_001, 8'd20, 1'b0, lat, ecnt, res, s0f);
    chk("b2b1_res", res, 25);
    chk("b2b_ready_done", cmd_if.cmd_ready, 1);
    run_cmd(2'd2, 9'b000_110_000, 8'd100, 1'b0, lat, ecnt, res, s0f);
    chk("b2b2_lat", lat, 4);
    chk("b2b2_res", res, 102);
    chk("b2b2_ecnt", ecnt, 3);

    // Busy-time command noise is not latched
    @(negedge clk);
    run_cmd(2'd3, 9'b010_101_000, 8'd10, 1'b1, lat, ecnt, res, s0f);
    chk("noise_lat", lat, 5);
    chk("noise_res", res, 9);

    // Reset in the middle of STEP
    @(negedge clk);
    a_val = 8'd10;
    cmd_if.cmd_len = 2'd3; cmd_if.cmd_ops = 9'b010_101_000; cmd_if.cmd_valid = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midstep_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("midrst_outs", {s0, s1, s2, m, e, busy, done}, 0);
    chk("midrst_acc", acc, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cmd_if.cmd_ready, 1);
    chk("midrst_idle", {busy, done, e}, 0);
    chk("midrst_acc_after", acc, 0);

`ifdef ACCUM_CTRL_ABORT_EN
    // Abort during the first STEP: that step still loads, then hold, no done
    a_val = 8'd10;
    cmd_if.cmd_len = 2'd3; cmd_if.cmd_ops = 9'b010_101_000; cmd_if.cmd_valid = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_e", e, 0);
    chk("abort_busy", busy, 0);
    begin
      int seen_done;
      seen_done = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      chk("abort_no_done", seen_done, 0);
    end
    chk("abort_acc", acc, 13);
`endif

    // Randomized commands against the reference model
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      b_val = 8'($urandom); c_val = 8'($urandom); d_val = 8'($urandom);
      rlen  = 2'($urandom_range(0, 3));
      rops  = 9'($urandom);
      ra    = 8'($urandom);
      exp_r = ref_result(ra, int'(rlen), rops);
      exp_l = ref_loads(int'(rlen), rops);
      run_cmd(rlen, rops, ra, (rlen >= 2) && $urandom_range(0, 1) == 1, lat, ecnt, res, s0f);
      chk($sformatf("rnd%0d_lat", n), lat, int'(rlen) + 2);
      chk($sformatf("rnd%0d_res", n), res, exp_r);
      chk($sformatf("rnd%0d_ecnt", n), ecnt, exp_l);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
